// File: rtl/pio_rx_fifo.sv
// pio_rx_fifo: receive FIFO from a state machine's ISR to the bus RXF read port, with
// level/full/empty status and sticky RXSTALL/RXUNDER flags.
// Define PIO_RX_FIFO_JOIN_EN for FJOIN_RX support. The port is named rx_join because 'join' is a reserved word.
module pio_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             push_stall,
    output logic             rxstall,
    output logic             rxunder,
    input  logic             clr_rxstall,
`ifdef PIO_RX_FIFO_JOIN_EN
    input  logic             clr_rxunder,
    input  logic             rx_join
`else
    input  logic             clr_rxunder
`endif
);

`ifdef PIO_RX_FIFO_JOIN_EN
    localparam int unsigned MEM_DEPTH = 2 * DEPTH;
`else
    localparam int unsigned MEM_DEPTH = DEPTH;
`endif
    localparam int unsigned PW = LW - 1;
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [PW-1:0]    wptr, rptr, wptr_n, rptr_n, last_idx;
    logic [LW-1:0]    level_n, cap;
    logic             rxstall_n, rxunder_n;
    logic             clear, push_acc, pop_acc;

    // Capacity and the "discard everything" condition depend on the join mode.
`ifdef PIO_RX_FIFO_JOIN_EN
    logic join_q;
    assign cap   = join_q ? LW'(2 * DEPTH) : LW'(DEPTH);
    assign clear = flush || (rx_join != join_q);
`else
    assign cap   = LW'(DEPTH);
    assign clear = flush;
`endif

    assign last_idx   = PW'(cap - LW'(1));
    assign full       = (level == cap);
    assign empty      = (level == '0);
    assign push_stall = push && full && !pop;
    assign pop_acc    = pop && !empty && !clear;
    assign push_acc   = push && (!full || pop) && !clear;
    assign dout       = empty ? '0 : mem[rptr[AW-1:0]];

    // Next-state for pointers, level and sticky flags; a flag's set beats its clear.
    always_comb begin
        wptr_n    = wptr;
        rptr_n    = rptr;
        level_n   = level;
        rxstall_n = push_stall || (rxstall && !clr_rxstall);
        rxunder_n = (pop && empty) || (rxunder && !clr_rxunder);
        if (clear) begin
            wptr_n  = '0;
            rptr_n  = '0;
            level_n = '0;
        end else begin
            if (push_acc) begin
                wptr_n = (wptr == last_idx) ? '0 : wptr + PW'(1);
            end
            if (pop_acc) begin
                rptr_n = (rptr == last_idx) ? '0 : rptr + PW'(1);
            end
            level_n = level + LW'(push_acc) - LW'(pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rxstall <= 1'b0;
            rxunder <= 1'b0;
`ifdef PIO_RX_FIFO_JOIN_EN
            join_q  <= 1'b0;
`endif
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            level   <= level_n;
            rxstall <= rxstall_n;
            rxunder <= rxunder_n;
`ifdef PIO_RX_FIFO_JOIN_EN
            join_q  <= rx_join;
`endif
        end
    end

    // Data array carries no reset; dout masks stale entries via empty.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_pio_rx_fifo.sv
// tb_pio_rx_fifo: table-driven bench for pio_rx_fifo with a data scoreboard queue.
// Define PIO_RX_FIFO_JOIN_EN to also exercise the joined mode.
module tb_pio_rx_fifo;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LW    = 4;
    localparam int          CAP   = 4;

    logic             clk = 1'b0;
    logic             reset, flush, push, pop, clr_rxstall, clr_rxunder;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full, empty, push_stall, rxstall, rxunder;
    logic [LW-1:0]    level;
`ifdef PIO_RX_FIFO_JOIN_EN
    logic             rx_join = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        push;
        logic [31:0] din;
        logic        pop;
        logic        flush;
        logic        cs;
        logic        cu;
        int          lvl;
        logic        pstall;
        logic        st;
        logic        un;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    pio_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LW(LW)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .push(push),
        .din(din),
        .pop(pop),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(level),
        .push_stall(push_stall),
        .rxstall(rxstall),
        .rxunder(rxunder),
        .clr_rxstall(clr_rxstall),
`ifdef PIO_RX_FIFO_JOIN_EN
        .clr_rxunder(clr_rxunder),
        .rx_join(rx_join)
`else
        .clr_rxunder(clr_rxunder)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        clr_rxstall = 1'b0; clr_rxunder = 1'b0; din = '0;
    endtask

    // Drive one vector: comb checks before the edge, state checks after it.
    task automatic apply(input vec_t t, input int idx);
        int sz;
        push = t.push; din = t.din; pop = t.pop; flush = t.flush;
        clr_rxstall = t.cs; clr_rxunder = t.cu;
        #1;
        chk($sformatf("v%0d.push_stall", idx), 32'(push_stall), 32'(t.pstall));
        sz = exp_q.size();
        if (t.flush) begin
            exp_q.delete();
        end else begin
            if (t.pop && sz > 0) begin
                chk($sformatf("v%0d.pop_data", idx), dout, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (t.push && (sz < CAP || t.pop)) exp_q.push_back(t.din);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        chk($sformatf("v%0d.level", idx), 32'(level), 32'(t.lvl));
        chk($sformatf("v%0d.empty", idx), 32'(empty), 32'(t.lvl == 0));
        chk($sformatf("v%0d.full", idx), 32'(full), 32'(t.lvl == CAP));
        chk($sformatf("v%0d.rxstall", idx), 32'(rxstall), 32'(t.st));
        chk($sformatf("v%0d.rxunder", idx), 32'(rxunder), 32'(t.un));
        chk($sformatf("v%0d.head", idx), dout, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
    endtask

    task automatic step(input logic p, input logic [31:0] d, input logic q);
        push = p; din = d; pop = q;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        //            push din           pop fl cs cu lvl ps st un
        vecs[0]  = '{1, 32'h11111111, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[1]  = '{1, 32'h22222222, 0, 0, 0, 0, 2, 0, 0, 0};
        vecs[2]  = '{1, 32'h33333333, 0, 0, 0, 0, 3, 0, 0, 0};
        vecs[3]  = '{1, 32'h44444444, 0, 0, 0, 0, 4, 0, 0, 0};
        vecs[4]  = '{1, 32'hDEADBEEF, 0, 0, 0, 0, 4, 1, 1, 0};
        vecs[5]  = '{0, 32'h0,        1, 0, 0, 0, 3, 0, 1, 0};
        vecs[6]  = '{1, 32'hAAAA0000, 0, 0, 1, 0, 4, 0, 0, 0};
        vecs[7]  = '{1, 32'h00000055, 1, 0, 0, 0, 4, 0, 0, 0};
        vecs[8]  = '{0, 32'h0,        1, 0, 0, 0, 3, 0, 0, 0};
        vecs[9]  = '{0, 32'h0,        1, 0, 0, 0, 2, 0, 0, 0};
        vecs[10] = '{0, 32'h0,        1, 0, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{0, 32'h0,        1, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 32'h000000A5, 1, 0, 0, 0, 1, 0, 0, 1};
        vecs[13] = '{0, 32'h0,        1, 0, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 1};
        vecs[15] = '{0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 0};
        vecs[16] = '{1, 32'h00000001, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[17] = '{1, 32'h00000002, 0, 0, 0, 0, 2, 0, 0, 0};
        vecs[18] = '{1, 32'h00000003, 0, 0, 0, 0, 3, 0, 0, 0};
        vecs[19] = '{1, 32'h00000004, 0, 0, 0, 0, 4, 0, 0, 0};
        vecs[20] = '{1, 32'h00000005, 0, 0, 0, 0, 4, 1, 1, 0};
        vecs[21] = '{0, 32'h0,        1, 0, 0, 0, 3, 0, 1, 0};
        vecs[22] = '{1, 32'h00000077, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[23] = '{1, 32'h00000088, 0, 0, 0, 0, 1, 0, 1, 0};

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset.level", 32'(level), 32'h0);
        chk("reset.empty", 32'(empty), 32'h1);
        chk("reset.full", 32'(full), 32'h0);
        chk("reset.dout", dout, 32'h0);
        chk("reset.flags", {30'h0, rxstall, rxunder}, 32'h0);

        for (int i = 0; i < NV; i++) apply(vecs[i], i);

        // Reset mid-operation outranks a concurrent push and clears the sticky flag.
        reset = 1'b1; push = 1'b1; din = 32'h99999999;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        exp_q.delete();
        chk("midreset.level", 32'(level), 32'h0);
        chk("midreset.empty", 32'(empty), 32'h1);
        chk("midreset.rxstall", 32'(rxstall), 32'h0);
        chk("midreset.dout", dout, 32'h0);

        // Wrap-around: stream data through the pointers with overlapping push/pop.
        step(1'b1, 32'hC0000000, 1'b0);
        for (int i = 1; i < 10; i++) begin
            chk($sformatf("wrap%0d.dout", i), dout, 32'hC0000000 + 32'(i - 1));
            step(1'b1, 32'hC0000000 + 32'(i), 1'b1);
            chk($sformatf("wrap%0d.level", i), 32'(level), 32'h1);
        end
        chk("wrap.last", dout, 32'hC0000009);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap.empty", 32'(empty), 32'h1);

`ifdef PIO_RX_FIFO_JOIN_EN
        step(1'b1, 32'h0000D001, 1'b0);
        step(1'b1, 32'h0000D002, 1'b0);
        chk("join.pre_level", 32'(level), 32'h2);
        rx_join = 1'b1;
        step(1'b1, 32'h0000D003, 1'b0);
        chk("join.switch_level", 32'(level), 32'h0);
        chk("join.switch_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hE0000000 + 32'(i), 1'b0);
            chk($sformatf("join.fill%0d.full", i), 32'(full), 32'(i == 7));
            chk($sformatf("join.fill%0d.level", i), 32'(level), 32'(i + 1));
        end
        chk("join.head", dout, 32'hE0000000);
        rx_join = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        chk("unjoin.level", 32'(level), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hF0000000 + 32'(i), 1'b0);
        chk("unjoin.full", 32'(full), 32'h1);
        chk("unjoin.level4", 32'(level), 32'h4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_rx_fifo.md
Name: pio_rx_fifo

Overview:
- Receive FIFO between one state machine's ISR and the system bus.
- A push (explicit PUSH or autopush) writes the 32-bit ISR contents into this FIFO. The bus-side register read of RXF pops it.
- Provides the full/empty/level status that the state machine uses for stall decisions.
- Provides the sticky RXSTALL/RXUNDER debug flags for the FDEBUG register.

Parameters:
- DEPTH, 4: entries in non-joined mode. Must be a power of two, ≥2.
- WIDTH, 32: data width. Matches the ISR.
- LW, 4: level/pointer width. Must hold 2*DEPTH, i.e. $clog2(2*DEPTH)+1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous empty; contents discarded, flags kept
- push  in  1  write request from the state machine
- din  in  WIDTH  ISR contents to store
- pop  in  1  read request from the bus (RXF read strobe)
- dout  out  WIDTH  head entry, show-ahead; 0 when empty
- full  out  1  level == capacity
- empty  out  1  level == 0
- level  out  LW  current entry count, 0..capacity
- push_stall  out  1  combinational: push && full && !pop
- rxstall  out  1  sticky: a push was dropped
- rxunder  out  1  sticky: a pop occurred while empty
- clr_rxstall  in  1  write-1-to-clear strobe for rxstall
- clr_rxunder  in  1  write-1-to-clear strobe for rxunder

Behaviour:
- Storage
  - Circular buffer of capacity entries.
  - Write pointer and read pointer, each LW-1 bits, wrap modulo capacity.
  - level is a registered counter.
- Reset values
  - Pointers, level, rxstall and rxunder are all 0.
  - Resulting outputs: empty=1, full=0, dout=0.
- Push
  - Accepted when !full, or when full && pop in the same cycle.
  - Entry is written at the write pointer on the clock edge. The pointer increments.
  - The new data is visible on dout one cycle later if the FIFO was empty. There is no same-cycle bypass.
- Push while full without pop
  - Data is dropped. No state change except the flag.
  - push_stall is 1 in that cycle.
  - rxstall is set at the edge.
  - The state machine is responsible for stalling and retrying. This block only reports.
- Pop
  - Accepted when !empty. The read pointer increments. dout advances to the next entry at the edge.
- Pop while empty
  - No pointer change. rxunder is set.
  - If a push is also present, the push is still accepted and rxunder is still set.
- Simultaneous push and pop, non-empty and non-full: both are performed and level is unchanged.
- Level update
  - level += push_accepted − pop_accepted.
  - level never exceeds capacity and never underflows.
- Flag clear
  - clr_* clears the flag at the edge.
  - If the flag's set condition is true in the same cycle, set wins.
- Flush
  - Flush has priority over push and pop in the same cycle.
  - Pointers and level go to 0 at the edge. Any push or pop in that cycle is ignored.
  - rxstall and rxunder are unaffected.
- Reset mid-operation: everything returns to reset values at the edge. Reset outranks flush, push, pop and clear.
- dout
  - Combinational read of the entry at the read pointer.
  - Forced to 0 when empty.

Optional Feature:
- Macro: PIO_RX_FIFO_JOIN_EN
- With the macro:
  - Adds input port join (1 bit), corresponding to FJOIN_RX.
  - A registered copy join_q selects capacity: 2*DEPTH when join_q=1, DEPTH otherwise.
  - When join != join_q at an edge, the block does the following at that edge:
    - join_q <= join
    - pointers and level cleared, as for flush
    - push and pop in that cycle ignored
    - flags kept
  - All full/level rules use the current capacity.
- Without the macro:
  - No join port.
  - Capacity fixed at DEPTH.
  - Storage is only DEPTH entries.

Test Plan:
- Reset, then push 0x11111111..0x44444444 over 4 cycles → level=4, full=1. Pop 4 times → dout sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444. Then empty=1, dout=0.
- Full FIFO, push 0xDEADBEEF with no pop → push_stall=1 that cycle, rxstall=1 next cycle, level stays 4. Popped contents do not include 0xDEADBEEF. clr_rxstall → rxstall=0.
- Full FIFO, push 0x55 and pop together → level stays 4. Head advances to the second entry. 0x55 is the last entry popped after all others.
- Empty FIFO, pop and push 0xA5 together → rxunder=1, level=1, dout=0xA5 next cycle. Same-cycle clr_rxunder with another empty pop → rxunder stays 1.
- Level 3 with rxstall=1, assert flush together with push → level=0, empty=1, rxstall still 1. Reset → rxstall=0.
- (PIO_RX_FIFO_JOIN_EN) Set join=1 with 2 entries stored → FIFO empty next cycle. Push 8 values → full=1 only after the 8th, level=8. Set join=0 → flush, capacity returns to 4.
